// File: rtl/weight_update_unit.sv
// Purpose: one gradient-descent step on the output neuron's two weights (err = final - target); optional delta clip via GRAD_CLIP_EN.
// Latency: start sampled at edge 1; w0 after edge 3, w1 and done after edge 4, idle again after edge 5; converged path done after edge 2.
// Backpressure: none; start_i is only honoured in IDLE and is dropped (not queued) while busy_o is high.
module weight_update_unit #(
    parameter int LR_SHIFT = 6,
    parameter int CLIP     = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [18:0] final_i,
    input  logic [3:0]  target_i,
    input  logic [9:0]  x0_i,
    input  logic [9:0]  x1_i,
    input  logic [15:0] weights_i,
    output logic [7:0]  w0_o,
    output logic [7:0]  w1_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        converged_o,
    output logic [7:0]  epoch_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERR   = 3'd1,
        S_GRAD0 = 3'd2,
        S_GRAD1 = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [18:0]        final_q;
    logic [3:0]         target_q;
    logic [9:0]         x0_q;
    logic [9:0]         x1_q;
    logic [15:0]        weights_q;
    logic signed [19:0] err_q;

    logic signed [19:0] err_next;
    logic [9:0]         x_sel;
    logic [7:0]         w_sel;
    logic signed [30:0] prod;
    logic signed [30:0] delta;
    logic signed [31:0] delta_ext;
    logic signed [31:0] delta_use;
    logic signed [31:0] new_w;
    logic [7:0]         w_new;

`ifdef GRAD_CLIP_EN
    localparam logic signed [31:0] CLIP_S = 32'(CLIP);
`else
    // CLIP has no role when clipping is compiled out; tie it off to a named sink.
    logic clip_unused;
    assign clip_unused = (CLIP != 0);
`endif

    // Error from the captured operands, and one shared gradient datapath for whichever weight is being stepped.
    always_comb begin
        err_next  = $signed({1'b0, final_q}) - $signed({16'b0, target_q});
        x_sel     = (state == S_GRAD1) ? x1_q : x0_q;
        w_sel     = (state == S_GRAD1) ? weights_q[15:8] : weights_q[7:0];
        prod      = {{11{err_q[19]}}, err_q} * $signed({21'b0, x_sel});
        delta     = prod >>> LR_SHIFT;
        delta_ext = {delta[30], delta};
        delta_use = delta_ext;
`ifdef GRAD_CLIP_EN
        if (delta_ext > CLIP_S) begin
            delta_use = CLIP_S;
        end else if (delta_ext < -CLIP_S) begin
            delta_use = -CLIP_S;
        end
`endif
        new_w = $signed({24'b0, w_sel}) - delta_use;
        if (new_w < 0) begin
            w_new = 8'd0;
        end else if (new_w > 32'sd255) begin
            w_new = 8'd255;
        end else begin
            w_new = new_w[7:0];
        end
    end

    // Update sequencer: capture, error, two weight steps, done pulse; all outputs registered.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            final_q     <= '0;
            target_q    <= '0;
            x0_q        <= '0;
            x1_q        <= '0;
            weights_q   <= '0;
            err_q       <= '0;
            w0_o        <= '0;
            w1_o        <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            converged_o <= 1'b0;
            epoch_o     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        final_q     <= final_i;
                        target_q    <= target_i;
                        x0_q        <= x0_i;
                        x1_q        <= x1_i;
                        weights_q   <= weights_i;
                        w0_o        <= weights_i[7:0];
                        w1_o        <= weights_i[15:8];
                        converged_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state       <= S_ERR;
                    end
                end
                S_ERR: begin
                    err_q <= err_next;
                    if (err_next == 20'sd0) begin
                        converged_o <= 1'b1;
                        done_o      <= 1'b1;
                        state       <= S_DONE;
                    end else begin
                        state <= S_GRAD0;
                    end
                end
                S_GRAD0: begin
                    w0_o  <= w_new;
                    state <= S_GRAD1;
                end
                S_GRAD1: begin
                    w1_o <= w_new;
                    if (epoch_o != 8'hff) begin
                        epoch_o <= epoch_o + 8'd1;
                    end
                    done_o <= 1'b1;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_update_unit.sv
// Bench for weight_update_unit: directed test-plan scenarios then randomized updates against an arithmetic reference.
// Reference uses floor division and plain integer clamping on the update rule; expected epoch tracked as a saturating count.
// Inputs are driven on the falling edge, outputs sampled on the falling edge after each rising edge.
module tb_weight_update_unit;

    localparam int LR   = 6;
    localparam int CLIP = 16;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [18:0] final_i;
    logic [3:0]  target_i;
    logic [9:0]  x0_i;
    logic [9:0]  x1_i;
    logic [15:0] weights_i;
    logic [7:0]  w0_o;
    logic [7:0]  w1_o;
    logic        busy_o;
    logic        done_o;
    logic        converged_o;
    logic [7:0]  epoch_o;

    int checks    = 0;
    int errors    = 0;
    int exp_epoch = 0;
    int done_cnt  = 0;

    weight_update_unit #(.LR_SHIFT(LR), .CLIP(CLIP)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .final_i     (final_i),
        .target_i    (target_i),
        .x0_i        (x0_i),
        .x1_i        (x1_i),
        .weights_i   (weights_i),
        .w0_o        (w0_o),
        .w1_o        (w1_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .converged_o (converged_o),
        .epoch_o     (epoch_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (done_o === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // w - floor(err*x / 2^LR), optionally clipped, clamped to a byte
    function automatic int model_w(int f, int t, int x, int w);
        longint err, prod, d, nw, div;
        div  = longint'(1) << LR;
        err  = longint'(f) - longint'(t);
        prod = err * longint'(x);
        if (prod >= 0) d = prod / div;
        else           d = -((-prod + div - 1) / div);
`ifdef GRAD_CLIP_EN
        if (d > CLIP)  d = CLIP;
        if (d < -CLIP) d = -CLIP;
`endif
        nw = longint'(w) - d;
        if (nw < 0)   nw = 0;
        if (nw > 255) nw = 255;
        return int'(nw);
    endfunction

    task automatic scramble();
        final_i   = 19'($urandom);
        target_i  = 4'($urandom);
        x0_i      = 10'($urandom);
        x1_i      = 10'($urandom);
        weights_i = 16'($urandom);
    endtask

    task automatic launch(input int f, input int t, input int a, input int b, input logic [15:0] w);
        @(negedge clk_i);
        final_i   = 19'(f);
        target_i  = 4'(t);
        x0_i      = 10'(a);
        x1_i      = 10'(b);
        weights_i = w;
        start_i   = 1'b1;
        @(posedge clk_i);
    endtask

    // Called just after edge 1; checks every following edge of the update.
    task automatic track(input int f, input int t, input int a, input int b, input logic [15:0] w,
                         input bit keep, input bit pulse);
        int e0, e1;
        bit conv;
        conv = (f == t);
        e0 = conv ? int'(w[7:0])  : model_w(f, t, a, int'(w[7:0]));
        e1 = conv ? int'(w[15:8]) : model_w(f, t, b, int'(w[15:8]));
        if (!conv) exp_epoch = (exp_epoch < 255) ? exp_epoch + 1 : 255;
        @(negedge clk_i);
        if (!keep) start_i = 1'b0;
        scramble();
        chk("e1_busy", 32'(busy_o), 32'd1);
        chk("e1_done", 32'(done_o), 32'd0);
        chk("e1_conv", 32'(converged_o), 32'd0);
        chk("e1_w0_load", 32'(w0_o), 32'(w[7:0]));
        chk("e1_w1_load", 32'(w1_o), 32'(w[15:8]));
        @(posedge clk_i); @(negedge clk_i);
        if (conv) begin
            chk("cv_done", 32'(done_o), 32'd1);
            chk("cv_conv", 32'(converged_o), 32'd1);
            chk("cv_w0", 32'(w0_o), 32'(e0));
            chk("cv_w1", 32'(w1_o), 32'(e1));
            chk("cv_epoch", 32'(epoch_o), 32'(exp_epoch));
            @(posedge clk_i); @(negedge clk_i);
            chk("cv_e3_done", 32'(done_o), 32'd0);
            chk("cv_e3_busy", 32'(busy_o), 32'd0);
            chk("cv_e3_conv", 32'(converged_o), 32'd1);
        end else begin
            chk("e2_done", 32'(done_o), 32'd0);
            chk("e2_busy", 32'(busy_o), 32'd1);
            if (pulse) begin
                start_i = 1'b1;
                scramble();
            end
            @(posedge clk_i); @(negedge clk_i);
            if (!keep) start_i = 1'b0;
            chk("e3_w0", 32'(w0_o), 32'(e0));
            chk("e3_w1_hold", 32'(w1_o), 32'(w[15:8]));
            chk("e3_done", 32'(done_o), 32'd0);
            @(posedge clk_i); @(negedge clk_i);
            chk("e4_w1", 32'(w1_o), 32'(e1));
            chk("e4_w0", 32'(w0_o), 32'(e0));
            chk("e4_done", 32'(done_o), 32'd1);
            chk("e4_epoch", 32'(epoch_o), 32'(exp_epoch));
            chk("e4_conv", 32'(converged_o), 32'd0);
            @(posedge clk_i); @(negedge clk_i);
            chk("e5_busy", 32'(busy_o), 32'd0);
            chk("e5_done", 32'(done_o), 32'd0);
        end
    endtask

    initial begin
        int f, t, a, b, d0;
        logic [15:0] w;
        rst_i = 1'b0; start_i = 1'b0;
        final_i = '0; target_i = '0; x0_i = '0; x1_i = '0; weights_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_w0", 32'(w0_o), 32'd0);
        chk("rst_w1", 32'(w1_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_conv", 32'(converged_o), 32'd0);
        chk("rst_epoch", 32'(epoch_o), 32'd0);
        rst_i = 1'b1;

        // basic step
        launch(10, 2, 64, 0, {8'd50, 8'd100});
        track(10, 2, 64, 0, {8'd50, 8'd100}, 0, 0);
        chk("basic_w0", 32'(w0_o), 32'd92);
        chk("basic_w1", 32'(w1_o), 32'd50);
        chk("basic_epoch", 32'(epoch_o), 32'd1);

        // upper saturation
        launch(0, 5, 128, 0, {8'd7, 8'd250});
        track(0, 5, 128, 0, {8'd7, 8'd250}, 0, 0);
        chk("upsat_w0", 32'(w0_o), 32'd255);

        // large error
        launch(100, 0, 64, 0, {8'd9, 8'd100});
        track(100, 0, 64, 0, {8'd9, 8'd100}, 0, 0);
`ifdef GRAD_CLIP_EN
        chk("large_w0", 32'(w0_o), 32'd84);
`else
        chk("large_w0", 32'(w0_o), 32'd0);
`endif

        // converged
        launch(3, 3, 17, 29, 16'h3214);
        track(3, 3, 17, 29, 16'h3214, 0, 0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("conv_w0", 32'(w0_o), 32'h14);
        chk("conv_w1", 32'(w1_o), 32'h32);
        chk("conv_hold", 32'(converged_o), 32'd1);
        chk("conv_epoch", 32'(epoch_o), 32'd3);

        // start pulse during GRAD0 is ignored
        d0 = done_cnt;
        launch(20, 1, 300, 500, {8'd120, 8'd140});
        track(20, 1, 300, 500, {8'd120, 8'd140}, 0, 1);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        chk("pulse_one_done", 32'(done_cnt - d0), 32'd1);
        chk("pulse_idle", 32'(busy_o), 32'd0);

        // start held high: second capture on edge 6
        launch(12, 4, 100, 200, {8'd60, 8'd70});
        track(12, 4, 100, 200, {8'd60, 8'd70}, 1, 0);
        final_i = 19'd30; target_i = 4'd9; x0_i = 10'd77; x1_i = 10'd900; weights_i = {8'd33, 8'd44};
        @(posedge clk_i);
        track(30, 9, 77, 900, {8'd33, 8'd44}, 0, 0);

        // reset during GRAD1
        d0 = done_cnt;
        launch(40, 2, 500, 600, {8'd128, 8'd128});
        @(negedge clk_i); start_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("mid_rst_w0", 32'(w0_o), 32'd0);
        chk("mid_rst_w1", 32'(w1_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_epoch", 32'(epoch_o), 32'd0);
        chk("mid_rst_conv", 32'(converged_o), 32'd0);
        exp_epoch = 0;
        @(posedge clk_i); @(negedge clk_i);
        rst_i = 1'b1;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        chk("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
        launch(9, 1, 32, 64, {8'd10, 8'd20});
        track(9, 1, 32, 64, {8'd10, 8'd20}, 0, 0);

        // randomized updates, long enough to saturate epoch
        for (int i = 0; i < 300; i++) begin
            f = (i % 10 == 0) ? int'(19'($urandom)) : int'($urandom_range(0, 40));
            t = int'($urandom_range(0, 15));
            if (i % 15 == 0) f = t;
            a = int'(10'($urandom));
            b = int'(10'($urandom));
            w = 16'($urandom);
            launch(f, t, a, b, w);
            track(f, t, a, b, w, 0, 0);
        end
        chk("epoch_final", 32'(epoch_o), 32'(exp_epoch));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_update_unit.md
# weight_update_unit

Backpropagation stage directly downstream of the output neuron. On `start_i` it captures the neuron's registered result, the training target, the two neuron inputs and the packed weights. It then computes the error and applies one gradient-descent step to each weight in turn through a small state machine. The updated weights feed back to the output neuron's `w0_i`/`w1_i` for the next forward pass.

## Interface
Parameters:
- `LR_SHIFT`, default 6: learning rate as a right shift; delta = (err·x) >>> LR_SHIFT.
- `CLIP`, default 16: delta magnitude limit, used only when `GRAD_CLIP_EN` is defined.

Ports:
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  begin one update; sampled only in IDLE.
- `final_i`  in  19  output neuron result, unsigned.
- `target_i`  in  4  training target, unsigned.
- `x0_i`, `x1_i`  in  10  neuron inputs, unsigned.
- `weights_i`  in  16  packed weights {w1, w0}, each unsigned 8-bit.
- `w0_o`, `w1_o`  out  8  current weights.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse at end of update.
- `converged_o`  out  1  last update saw err == 0.
- `epoch_o`  out  8  count of non-converged updates, saturating.

## Operation
- States: IDLE, ERR, GRAD0, GRAD1, DONE.
- IDLE with `start_i`=1:
  - capture `final_i`, `target_i`, `x0_i`, `x1_i`, `weights_i` into internal registers;
  - load `w0_o`/`w1_o` from `weights_i`;
  - clear `converged_o`;
  - go to ERR.
- ERR:
  - register err = {1'b0, final} − {16'b0, target}, as signed 20-bit;
  - if err == 0: set `converged_o`, go to DONE;
  - otherwise go to GRAD0.
- GRAD0: update w0 from err and x0; go to GRAD1.
- GRAD1: update w1 from err and x1; increment `epoch_o`, saturating at 255; go to DONE.
- DONE: `done_o`=1; go to IDLE.
- Gradient arithmetic for each weight:
  - prod = err × $signed({1'b0, x}), 31-bit signed;
  - delta = prod >>> LR_SHIFT, arithmetic shift;
  - new_w = w − delta, evaluated at ≥32-bit signed width;
  - clamp new_w to [0, 255].
- `start_i` outside IDLE is ignored; no queueing.
- Input changes after the capture edge have no effect on the update in progress.
- Converged path leaves both weights and `epoch_o` unchanged.

## Timing
- Reset values: state IDLE; `w0_o`=0, `w1_o`=0, `busy_o`=0, `done_o`=0, `converged_o`=0, `epoch_o`=0; err and captured registers 0.
- Reset asserted mid-update: immediate return to IDLE with all reset values; no `done_o` pulse.
- Edge numbering: edge 1 is the edge that samples `start_i`.
  - `busy_o` rises after edge 1.
  - Normal path: `w0_o` is valid after edge 3 and `w1_o` after edge 4. `done_o` is high between edges 4 and 5, and `busy_o` falls after edge 5.
  - Converged path: `done_o` is high between edges 2 and 3.
- `start_i` held high continuously: the next update is captured on the first edge where the block is in IDLE, i.e. edge 6.
- `converged_o` and `epoch_o` hold their values between updates.

## Configuration
- `GRAD_CLIP_EN` defined: each delta is clamped to [−CLIP, +CLIP] before subtraction; the [0, 255] weight clamp still applies afterwards.
- `GRAD_CLIP_EN` undefined: delta is used unclipped; only the [0, 255] weight clamp applies. The `CLIP` parameter is unused.

## Test plan
All scenarios use LR_SHIFT=6.
- Basic step: final=10, target=2, x0=64, x1=0, w0=100, w1=50 → err=8, w0_o=92, w1_o=50, done_o pulse between edges 4 and 5, epoch_o=1.
- Upper saturation: final=0, target=5, x0=128, w0=250 → delta=−10, w0_o=255 rather than 260.
- Large error, macro off vs on: final=100, target=0, x0=64, w0=100 → w0_o=0 without `GRAD_CLIP_EN`; w0_o=84 with `GRAD_CLIP_EN` and CLIP=16.
- Converged: final=3, target=3, weights=16'h3214 → converged_o=1, w0_o=8'h14, w1_o=8'h32, done_o between edges 2 and 3, epoch_o unchanged.
- Busy/start interaction: pulse start_i again during GRAD0 with different inputs → ignored, exactly one done_o. With start_i held high, the second capture occurs on edge 6.
- Reset mid-update: assert rst_i low in GRAD1 → all outputs 0 immediately; no done_o; after release the block accepts a new start.
